// File: rtl/ps2_keyboard_controller_if.sv
// CPU-side read bus of the PS/2 keyboard controller: decoded address, read strobe,
// registered read data and the FIFO-non-empty interrupt.
interface ps2_keyboard_controller_if;
  logic [13:0] address;
  logic        read_en;
  logic [63:0] data;
  logic        irq;

  modport master (
    output address,
    output read_en,
    input  data,
    input  irq
  );

  modport slave (
    input  address,
    input  read_en,
    output data,
    output irq
  );
endinterface

// File: rtl/ps2_keyboard_controller.sv
// PS/2 keyboard receiver: synchronises the PS/2 lines, frames 11-bit packets and queues
// scancodes for CPU reads. Define PS2_PARITY_CHECK_EN to enforce odd parity on each frame.
module ps2_keyboard_controller #(
  parameter logic [13:0] KBD_ADDR       = 14'h3ffe,
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 5000,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic                     system_clk,
  input  logic                     reset,
  input  logic                     PS2_clk,
  input  logic                     PS2_data,
  ps2_keyboard_controller_if.slave bus
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [13:0]     DataAddr = KBD_ADDR + 14'd1;
  localparam logic [TmoW-1:0] TmoLast  = TmoW'(TIMEOUT_CYCLES - 1);
  localparam logic [CntW-1:0] CntFull  = CntW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    StIdle,
    StData,
    StParity,
    StStop
  } state_e;

  // Input synchronisers and fall detection
  logic [SYNC_STAGES-1:0] clk_sync_q;
  logic [SYNC_STAGES-1:0] data_sync_q;
  logic                   clk_prev_q;
  logic                   ps2_clk_s;
  logic                   ps2_data_s;
  logic                   ps2_fall;

  // Lines idle high, so reset to 1 to avoid a phantom fall after reset release.
  always_ff @(posedge system_clk or negedge reset) begin
    if (!reset) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      clk_prev_q  <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], PS2_clk};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], PS2_data};
      clk_prev_q  <= clk_sync_q[SYNC_STAGES-1];
    end
  end

  assign ps2_clk_s  = clk_sync_q[SYNC_STAGES-1];
  assign ps2_data_s = data_sync_q[SYNC_STAGES-1];
  assign ps2_fall   = clk_prev_q & ~ps2_clk_s;

  // Frame receiver
  state_e          state_q, state_d;
  logic [7:0]      shift_q, shift_d;
  logic [2:0]      bitcnt_q, bitcnt_d;
  logic            parity_q, parity_d;
  logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic            parity_ok;
  logic            push;
  logic            frame_err_set;
  logic            timeout_set;

`ifdef PS2_PARITY_CHECK_EN
  assign parity_ok = ^{shift_q, parity_q};
`else
  assign parity_ok = 1'b1;
`endif

  always_comb begin
    state_d       = state_q;
    shift_d       = shift_q;
    bitcnt_d      = bitcnt_q;
    parity_d      = parity_q;
    push          = 1'b0;
    frame_err_set = 1'b0;
    timeout_set   = 1'b0;
    tmo_cnt_d     = (ps2_fall || state_q == StIdle) ? '0 : tmo_cnt_q + TmoW'(1);

    if (ps2_fall) begin
      unique case (state_q)
        StIdle: begin
          if (!ps2_data_s) begin
            state_d  = StData;
            bitcnt_d = 3'd0;
          end
        end
        StData: begin
          shift_d  = {ps2_data_s, shift_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) begin
            state_d = StParity;
          end
        end
        StParity: begin
          parity_d = ps2_data_s;
          state_d  = StStop;
        end
        StStop: begin
          if (ps2_data_s && parity_ok) begin
            push = 1'b1;
          end else begin
            frame_err_set = 1'b1;
          end
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end else if (state_q != StIdle && tmo_cnt_q == TmoLast) begin
      state_d     = StIdle;
      timeout_set = 1'b1;
      tmo_cnt_d   = '0;
    end
  end

  always_ff @(posedge system_clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      shift_q   <= 8'h00;
      bitcnt_q  <= 3'd0;
      parity_q  <= 1'b0;
      tmo_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bitcnt_q  <= bitcnt_d;
      parity_q  <= parity_d;
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

  // Scancode FIFO and register interface
  logic [7:0]      fifo_mem [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            overflow_q, overflow_d;
  logic            frame_err_q, frame_err_d;
  logic            timeout_err_q, timeout_err_d;
  logic [63:0]     data_q, data_d;
  logic            irq_q;
  logic            empty;
  logic            full;
  logic            rd_status;
  logic            rd_pop_addr;
  logic            pop;
  logic            push_ok;
  logic [63:0]     status_word;

  assign empty       = (count_q == '0);
  assign full        = (count_q == CntFull);
  assign rd_status   = bus.read_en && (bus.address == KBD_ADDR);
  assign rd_pop_addr = bus.read_en && (bus.address == DataAddr);
  assign pop         = rd_pop_addr && !empty;
  // Fullness is judged before any same-cycle pop, so a push into a full FIFO is dropped.
  assign push_ok     = push && !full;

  always_comb begin
    status_word       = '0;
    status_word[0]    = empty;
    status_word[1]    = full;
    status_word[2]    = overflow_q;
    status_word[3]    = frame_err_q;
    status_word[4]    = timeout_err_q;
    status_word[15:8] = 8'(count_q);
  end

  always_comb begin
    wr_ptr_d = push_ok ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;

    case ({push_ok, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase

    // A status read clears the sticky flags, but a same-cycle set wins.
    overflow_d    = (overflow_q & ~rd_status) | (push & full);
    frame_err_d   = (frame_err_q & ~rd_status) | frame_err_set;
    timeout_err_d = (timeout_err_q & ~rd_status) | timeout_set;

    data_d = data_q;
    if (bus.read_en) begin
      if (rd_status) begin
        data_d = status_word;
      end else if (pop) begin
        data_d = {55'b0, 1'b1, fifo_mem[rd_ptr_q]};
      end else begin
        data_d = '0;
      end
    end
  end

  always_ff @(posedge system_clk) begin
    if (push_ok) begin
      fifo_mem[wr_ptr_q] <= shift_q;
    end
  end

  always_ff @(posedge system_clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      overflow_q    <= 1'b0;
      frame_err_q   <= 1'b0;
      timeout_err_q <= 1'b0;
      data_q        <= '0;
      irq_q         <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      overflow_q    <= overflow_d;
      frame_err_q   <= frame_err_d;
      timeout_err_q <= timeout_err_d;
      data_q        <= data_d;
      irq_q         <= ~empty;
    end
  end

  assign bus.data = data_q;
  assign bus.irq  = irq_q;

endmodule
